// File: rtl/key_debounce.sv
// key_debounce: eight-key debouncer with press-pulse detection and optional
// sticky press-pending flags plus an interrupt request.
// Optional feature macro: KEY_DEBOUNCE_IRQ_EN builds pend/clr/irq. Without it,
// pend and irq are tied low and clr/clr_mask are ignored.
// Each raw key is double-flopped, then has to hold its new level for
// DB_CYCLES consecutive synchronized samples before key_db follows it.
module key_debounce #(
    parameter int DB_CYCLES = 500000,
    parameter int CNT_WIDTH = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key_raw,
    output logic [7:0] key_db,
    output logic [7:0] key_press,
    output logic [7:0] pend,
    input  logic       clr,
    input  logic [7:0] clr_mask,
    output logic       irq
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DB_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [7:0]           sync_q1;
    logic [7:0]           sync_q2;
    logic [CNT_WIDTH-1:0] cnt_q [8];
    logic [7:0]           differ;
    logic [7:0]           accept;

    // Two-flop synchronizer; released level (1) is the reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 8'hFF;
            sync_q2 <= 8'hFF;
        end else begin
            sync_q1 <= key_raw;
            sync_q2 <= sync_q1;
        end
    end

    // A key is accepted when it has differed from key_db for the full window.
    always_comb begin
        differ = sync_q2 ^ key_db;
        accept = '0;
        for (int i = 0; i < 8; i++) begin
            accept[i] = differ[i] && (cnt_q[i] == CNT_LAST);
        end
    end

    // Per-key stability counters: any agreement with key_db restarts the
    // window, and acceptance clears the count, so the counter never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (!differ[i] || accept[i]) begin
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Debounced level and press pulse update on the same edge, so key_press
    // is high exactly in the first cycle key_db shows the new low level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_db    <= 8'hFF;
            key_press <= 8'h00;
        end else begin
            key_db    <= (key_db & ~accept) | (sync_q2 & accept);
            key_press <= accept & ~sync_q2;
        end
    end

`ifdef KEY_DEBOUNCE_IRQ_EN
    // Sticky pending flags; a new press wins over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 8'h00;
        end else begin
            pend <= (pend & ~(clr ? clr_mask : 8'h00)) | key_press;
        end
    end

    // Interrupt is a pure OR of the pending register.
    always_comb begin
        irq = |pend;
    end
`else
    logic unused_clr;

    // Pending/interrupt logic not built: outputs tied low, bus clear ignored.
    always_comb begin
        pend       = 8'h00;
        irq        = 1'b0;
        unused_clr = ^{clr, clr_mask};
    end
`endif

endmodule
